// File: rtl/hazard_unit_pkg.sv
// Shared types and constants for the pipeline interlock controller.
package hazard_unit_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    FLUSH   = 2'd1,
    MEMWAIT = 2'd2
  } state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam int         CNT_W    = 16;

endpackage

// File: rtl/hazard_unit_sat_counter.sv
// Saturating up-counter used for the stall/flush performance counters.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         r_count <= '0;
    else if (i_inc && r_count != '1) r_count <= r_count + 1'b1;
  end

  assign o_count = r_count;

endmodule

// File: rtl/hazard_unit.sv
// Stall/flush interlock for the 5-stage MIPS pipeline: memory freeze,
// branch flush and load-use bubble, in that priority order.
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int BRANCH_PENALTY = 2,
  parameter int MEM_TIMEOUT    = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       IFIDinstrRs2521,
  input  logic [4:0]       IFIDinstrRt2016,
  input  logic             IFIDuseRt,
  input  logic             IDEXMemRead,
  input  logic [4:0]       IDEXinstrRt2016,
  input  logic             branchTaken,
  input  logic             memReq,
  input  logic             memReady,
  output logic             PCWrite,
  output logic             IFIDWrite,
  output logic             IDEXWrite,
  output logic             EXMEMWrite,
  output logic             IFIDFlush,
  output logic             IDEXFlush,
  output logic             MEMWBBubble,
  output logic             memTimeout,
  output logic [CNT_W-1:0] stallCycles,
  output logic [CNT_W-1:0] flushCycles
);

  localparam logic [2:0] PEN_M1 = 3'(BRANCH_PENALTY - 1);
  localparam logic [7:0] TMO    = 8'(MEM_TIMEOUT);

  state_e     r_state, w_stateNext;
  logic [2:0] r_flushCnt, w_flushCntNext;
  logic [7:0] r_waitCnt, w_waitCntNext;
  logic       r_memTimeout;
  logic       w_freeze, w_flushPend, w_flush, w_loadUse, w_stall;

  assign w_freeze    = memReq && !memReady;
  // A flush interrupted by a freeze resumes in the cycle the freeze releases.
  assign w_flushPend = (r_state == FLUSH) || (r_state == MEMWAIT && r_flushCnt != 3'd0);
  assign w_flush     = !w_freeze && (branchTaken || w_flushPend);
  assign w_loadUse   = IDEXMemRead && (IDEXinstrRt2016 != REG_ZERO) &&
                       ((IDEXinstrRt2016 == IFIDinstrRs2521) ||
                        (IFIDuseRt && IDEXinstrRt2016 == IFIDinstrRt2016));
  assign w_stall     = !w_freeze && !w_flush && w_loadUse;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= RUN;
      r_flushCnt   <= 3'd0;
      r_waitCnt    <= 8'd0;
      r_memTimeout <= 1'b0;
    end else begin
      r_state    <= w_stateNext;
      r_flushCnt <= w_flushCntNext;
      r_waitCnt  <= w_waitCntNext;
      if (w_freeze && w_waitCntNext >= TMO) r_memTimeout <= 1'b1;
    end
  end

  always_comb begin
    w_stateNext    = RUN;
    w_flushCntNext = r_flushCnt;
    w_waitCntNext  = 8'd0;
    if (w_freeze) begin
      w_stateNext   = MEMWAIT;
      w_waitCntNext = (r_waitCnt == 8'hFF) ? r_waitCnt : r_waitCnt + 8'd1;
    end else if (branchTaken) begin
      w_flushCntNext = PEN_M1;
      w_stateNext    = (PEN_M1 == 3'd0) ? RUN : FLUSH;
    end else if (w_flushPend) begin
      w_flushCntNext = r_flushCnt - 3'd1;
      w_stateNext    = (r_flushCnt == 3'd1) ? RUN : FLUSH;
    end
  end

  always_comb begin
    PCWrite     = 1'b1;
    IFIDWrite   = 1'b1;
    IDEXWrite   = 1'b1;
    EXMEMWrite  = 1'b1;
    IFIDFlush   = 1'b0;
    IDEXFlush   = 1'b0;
    MEMWBBubble = 1'b0;
    if (!rst) begin
      if (w_freeze) begin
        PCWrite     = 1'b0;
        IFIDWrite   = 1'b0;
        IDEXWrite   = 1'b0;
        EXMEMWrite  = 1'b0;
        MEMWBBubble = 1'b1;
      end else if (w_flush) begin
        IFIDFlush = 1'b1;
        IDEXFlush = 1'b1;
      end else if (w_loadUse) begin
        PCWrite   = 1'b0;
        IFIDWrite = 1'b0;
        IDEXFlush = 1'b1;
      end
    end
  end

  assign memTimeout = r_memTimeout;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (w_freeze || w_stall),
    .o_count (stallCycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (w_flush),
    .o_count (flushCycles)
  );

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: vector table, corner sequences, random run.
module tb_hazard_unit;
  localparam int BP = 2;
  localparam int MT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs, rt, exrt;
  logic        useRt, memRead, br, memReq, memReady;
  logic        PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite, IFIDFlush, IDEXFlush, MEMWBBubble;
  logic        memTimeout;
  logic [15:0] stallCycles, flushCycles;
  logic [6:0]  dut7;

  hazard_unit #(.BRANCH_PENALTY(BP), .MEM_TIMEOUT(MT)) dut (
    .clk(clk), .rst(rst),
    .IFIDinstrRs2521(rs), .IFIDinstrRt2016(rt), .IFIDuseRt(useRt),
    .IDEXMemRead(memRead), .IDEXinstrRt2016(exrt),
    .branchTaken(br), .memReq(memReq), .memReady(memReady),
    .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .IDEXWrite(IDEXWrite), .EXMEMWrite(EXMEMWrite),
    .IFIDFlush(IFIDFlush), .IDEXFlush(IDEXFlush), .MEMWBBubble(MEMWBBubble),
    .memTimeout(memTimeout), .stallCycles(stallCycles), .flushCycles(flushCycles)
  );

  assign dut7 = {PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite, IFIDFlush, IDEXFlush, MEMWBBubble};

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] rs, rt, exrt;
    logic       useRt, memRead, br, req, rdy;
  } in_t;
  typedef struct {
    in_t        i;
    logic [6:0] exp;
  } vec_t;

  localparam logic [6:0] O_IDLE  = 7'b1111000;
  localparam logic [6:0] O_STALL = 7'b0011010;
  localparam logic [6:0] O_FLUSH = 7'b1111110;
  localparam logic [6:0] O_FRZ   = 7'b0000001;

  int checks = 0;
  int passes = 0;

  // reference model: remaining flush cycles, consecutive frozen cycles, counters
  int m_flushRem, m_waitRun, m_stall, m_flush;
  bit m_tmo;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  function automatic in_t mki(int a, int b, int c, bit u, bit m, bit t, bit q, bit y);
    in_t v;
    v.rs = 5'(a); v.rt = 5'(b); v.exrt = 5'(c);
    v.useRt = u; v.memRead = m; v.br = t; v.req = q; v.rdy = y;
    return v;
  endfunction

  function automatic bit lu(in_t v);
    return v.memRead && v.exrt != 5'd0 && (v.exrt == v.rs || (v.useRt && v.exrt == v.rt));
  endfunction

  task automatic model_reset();
    m_flushRem = 0; m_waitRun = 0; m_stall = 0; m_flush = 0; m_tmo = 0;
  endtask

  // Apply one cycle of inputs; checks outputs mid-cycle and counters after the edge.
  task automatic cycle(input in_t v, input string nm, output logic [6:0] seen);
    logic [6:0] e;
    bit frz;
    rs = v.rs; rt = v.rt; exrt = v.exrt; useRt = v.useRt;
    memRead = v.memRead; br = v.br; memReq = v.req; memReady = v.rdy;
    @(negedge clk);
    frz = v.req && !v.rdy;
    if (frz)                         e = O_FRZ;
    else if (v.br || m_flushRem > 0) e = O_FLUSH;
    else if (lu(v))                  e = O_STALL;
    else                             e = O_IDLE;
    seen = dut7;
    chk({nm, " outputs"}, 32'(dut7), 32'(e));
    @(posedge clk);
    if (frz) begin
      if (m_waitRun < 255) m_waitRun++;
      if (m_waitRun >= MT) m_tmo = 1;
      if (m_stall < 65535) m_stall++;
    end else begin
      m_waitRun = 0;
      if (v.br) begin
        m_flushRem = BP - 1;
        if (m_flush < 65535) m_flush++;
      end else if (m_flushRem > 0) begin
        m_flushRem--;
        if (m_flush < 65535) m_flush++;
      end else if (lu(v)) begin
        if (m_stall < 65535) m_stall++;
      end
    end
    #1;
    chk({nm, " stallCycles"}, 32'(stallCycles), 32'(m_stall));
    chk({nm, " flushCycles"}, 32'(flushCycles), 32'(m_flush));
    chk({nm, " memTimeout"},  32'(memTimeout),  32'(m_tmo));
  endtask

  vec_t       tab[12];
  in_t        idle, frz, rel;
  logic [6:0] o;
  int         f0;
  bit         pend;

  initial begin
    tab[0]  = '{mki(0, 0, 0, 0, 0, 0, 0, 0), O_IDLE};   // nothing going on
    tab[1]  = '{mki(8, 0, 8, 0, 1, 0, 0, 0), O_STALL};  // load $t0, rs=$t0
    tab[2]  = '{mki(0, 0, 0, 1, 1, 0, 0, 0), O_IDLE};   // load to $0 never stalls
    tab[3]  = '{mki(3, 8, 8, 0, 1, 0, 0, 0), O_IDLE};   // rt match but rt unused
    tab[4]  = '{mki(3, 8, 8, 1, 1, 0, 0, 0), O_STALL};  // rt match, rt used
    tab[5]  = '{mki(8, 8, 8, 1, 0, 0, 0, 0), O_IDLE};   // not a load
    tab[6]  = '{mki(8, 0, 8, 0, 1, 0, 1, 1), O_STALL};  // zero-wait access, no freeze
    tab[7]  = '{mki(8, 0, 8, 0, 1, 0, 1, 0), O_FRZ};    // freeze beats load-use
    tab[8]  = '{mki(8, 0, 8, 0, 1, 0, 1, 1), O_STALL};  // release re-evaluates load-use
    tab[9]  = '{mki(8, 0, 8, 0, 1, 1, 0, 0), O_FLUSH};  // branch beats load-use
    tab[10] = '{mki(8, 0, 8, 0, 1, 0, 0, 0), O_FLUSH};  // second penalty cycle
    tab[11] = '{mki(8, 0, 8, 0, 1, 0, 0, 0), O_STALL};  // flush over, stall visible
    idle = mki(0, 0, 0, 0, 0, 0, 0, 0);
    frz  = mki(0, 0, 0, 0, 0, 0, 1, 0);
    rel  = mki(0, 0, 0, 0, 0, 0, 1, 1);

    rst = 1'b1;
    rs = '0; rt = '0; exrt = '0; useRt = 0; memRead = 1; br = 0; memReq = 1; memReady = 0;
    model_reset();
    #12;
    chk("reset outputs", 32'(dut7), 32'(O_IDLE));
    chk("reset stallCycles", 32'(stallCycles), 0);
    chk("reset flushCycles", 32'(flushCycles), 0);
    chk("reset memTimeout", 32'(memTimeout), 0);
    memReq = 0; memRead = 0;
    rst = 1'b0;

    for (int k = 0; k < 12; k++) begin
      cycle(tab[k].i, $sformatf("vec%0d", k), o);
      chk($sformatf("vec%0d table", k), 32'(o), 32'(tab[k].exp));
    end

    // branch, then a 3-cycle freeze with one flush cycle still owed
    f0 = m_flush;
    cycle(mki(0, 0, 0, 0, 0, 1, 0, 0), "brf pulse", o);
    for (int k = 0; k < 3; k++) begin
      cycle(frz, "brf freeze", o);
      chk("brf freeze hand", 32'(o), 32'(O_FRZ));
    end
    cycle(rel, "brf release", o);
    chk("brf release hand", 32'(o), 32'(O_FLUSH));
    cycle(idle, "brf after", o);
    chk("brf after hand", 32'(o), 32'(O_IDLE));
    chk("brf total flushes", 32'(flushCycles), 32'(f0 + BP));

    // timeout after MT frozen cycles, sticky past release
    for (int k = 0; k < MT; k++) cycle(frz, "tmo freeze", o);
    chk("tmo raised", 32'(memTimeout), 1);
    cycle(rel, "tmo release", o);
    cycle(idle, "tmo idle", o);
    chk("tmo sticky", 32'(memTimeout), 1);

    // async reset in the middle of MEMWAIT
    cycle(frz, "rst pre", o);
    cycle(frz, "rst pre", o);
    #2 rst = 1'b1;
    #1;
    chk("midrst outputs", 32'(dut7), 32'(O_IDLE));
    chk("midrst stallCycles", 32'(stallCycles), 0);
    chk("midrst flushCycles", 32'(flushCycles), 0);
    chk("midrst memTimeout", 32'(memTimeout), 0);
    memReq = 0; memReady = 0;
    model_reset();
    @(negedge clk) rst = 1'b0;
    @(posedge clk) #1;
    cycle(idle, "post rst", o);

    pend = 0;
    for (int n = 0; n < 400; n++) begin
      in_t v;
      v.rs = 5'($urandom_range(0, 3));
      v.rt = 5'($urandom_range(0, 3));
      v.exrt = 5'($urandom_range(0, 3));
      v.useRt = 1'($urandom_range(0, 1));
      v.memRead = 1'($urandom_range(0, 1));
      v.req = pend ? 1'b1 : ($urandom_range(0, 3) == 0);
      v.rdy = ($urandom_range(0, 3) != 0);
      v.br = !(v.req && !v.rdy) && ($urandom_range(0, 5) == 0);
      cycle(v, "rand", o);
      pend = v.req && !v.rdy;
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
